// File: rtl/pool_ofm_unpack.sv
// Sparse OFM readback: rebuilds dense channel vectors from packed
// non-zero bytes and per-channel flag groups held in the global buffers.
module pool_ofm_unpack #(
  parameter int DATA_WIDTH          = 8,
  parameter int NUMPEB              = 16,
  parameter int PORT_DATAWIDTH      = 96,
  parameter int GBFOFM_ADDRWIDTH    = 10,
  parameter int GBFFLGOFM_ADDRWIDTH = 8,
  parameter int NUMVEC_WIDTH        = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           UNPK_Start,
  input  logic [NUMVEC_WIDTH-1:0]        UNPK_NumVec,
  output logic                           GBFOFM_EnRd,
  output logic [GBFOFM_ADDRWIDTH-1:0]    GBFOFM_AddrRd,
  input  logic [PORT_DATAWIDTH-1:0]      GBFOFM_DatRd,
  output logic                           GBFFLGOFM_EnRd,
  output logic [GBFFLGOFM_ADDRWIDTH-1:0] GBFFLGOFM_AddrRd,
  input  logic [PORT_DATAWIDTH-1:0]      GBFFLGOFM_DatRd,
  output logic [DATA_WIDTH*NUMPEB-1:0]   OFM_Dat,
  output logic                           OFM_Val,
  input  logic                           OFM_Rdy,
  output logic                           UNPK_Busy,
  output logic                           UNPK_Done
);

  localparam int W  = PORT_DATAWIDTH / DATA_WIDTH;
  localparam int G  = PORT_DATAWIDTH / NUMPEB;
  localparam int CW = $clog2(NUMPEB);
  localparam int BW = $clog2(W + 1);
  localparam int GW = $clog2(G);

  typedef enum logic [2:0] {
    IDLE, FLGRD, FLGLD, DEC, DATRD, DATLD, OUT, DONE
  } state_t;

  state_t state, state_nx;

  logic [PORT_DATAWIDTH-1:0]      flg_word, dat_word;
  logic [DATA_WIDTH*NUMPEB-1:0]   dat;
  logic [NUMVEC_WIDTH-1:0]        num_vec, vec_cnt;
  logic [GBFOFM_ADDRWIDTH-1:0]    dat_addr;
  logic [GBFFLGOFM_ADDRWIDTH-1:0] flg_addr;
  logic [CW-1:0]                  c, c_nx;
  logic [BW-1:0]                  b, b_nx;
  logic [GW-1:0]                  g;
  logic                           buf_v;
  logic [NUMPEB-1:0]              grp, grp_ld, grp_nx;
  logic [DATA_WIDTH-1:0]          cur;
  logic                           empty, empty_nx;
  logic                           last_ch, last_grp, last_vec;

  function automatic logic [NUMPEB-1:0] grp_of(
    input logic [PORT_DATAWIDTH-1:0] w,
    input int                        k
  );
    grp_of = '0;
    for (int i = 0; i < G; i++)
      if (i == k) grp_of = w[NUMPEB*i +: NUMPEB];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] byte_of(
    input logic [PORT_DATAWIDTH-1:0] w,
    input int                        k
  );
    byte_of = '0;
    for (int i = 0; i < W; i++)
      if (i == k) byte_of = w[DATA_WIDTH*i +: DATA_WIDTH];
  endfunction

  assign grp      = grp_of(flg_word, int'(g));
  assign grp_ld   = grp_of(GBFFLGOFM_DatRd, 0);
  assign grp_nx   = grp_of(flg_word, int'(g) + 1);
  assign cur      = byte_of(dat_word, int'(b));
  assign c_nx     = c + CW'(1);
  assign b_nx     = grp[c] ? b + BW'(1) : b;
  assign empty    = !buf_v || b == BW'(W);
  assign empty_nx = !buf_v || b_nx == BW'(W);
  assign last_ch  = c == CW'(NUMPEB - 1);
  assign last_grp = g == GW'(G - 1);
  assign last_vec = vec_cnt + NUMVEC_WIDTH'(1) == num_vec;

  // Refills are decided one step ahead so a data fetch never costs
  // an extra DEC cycle for the channel that needs it.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (UNPK_Start)
          state_nx = (UNPK_NumVec == '0) ? DONE : FLGRD;
      FLGRD: state_nx = FLGLD;
      FLGLD: state_nx = (grp_ld[0] && empty) ? DATRD : DEC;
      DEC:
        if (last_ch)                    state_nx = OUT;
        else if (grp[c_nx] && empty_nx) state_nx = DATRD;
        else                            state_nx = DEC;
      DATRD: state_nx = DATLD;
      DATLD: state_nx = DEC;
      OUT:
        if (OFM_Rdy) begin
          if (last_vec)                 state_nx = DONE;
          else if (last_grp)            state_nx = FLGRD;
          else if (grp_nx[0] && empty)  state_nx = DATRD;
          else                          state_nx = DEC;
        end
      DONE:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      flg_word <= '0;
      dat_word <= '0;
      dat      <= '0;
      num_vec  <= '0;
      vec_cnt  <= '0;
      dat_addr <= '0;
      flg_addr <= '0;
      c        <= '0;
      b        <= '0;
      g        <= '0;
      buf_v    <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE:
          if (UNPK_Start) begin
            num_vec  <= UNPK_NumVec;
            vec_cnt  <= '0;
            dat_addr <= '0;
            flg_addr <= '0;
            c        <= '0;
            b        <= '0;
            g        <= '0;
            buf_v    <= 1'b0;
          end
        FLGRD: flg_addr <= flg_addr + GBFFLGOFM_ADDRWIDTH'(1);
        FLGLD: begin
          flg_word <= GBFFLGOFM_DatRd;
          g        <= '0;
          c        <= '0;
          dat      <= '0;
        end
        DEC: begin
          if (grp[c]) begin
            dat[DATA_WIDTH*c +: DATA_WIDTH] <= cur;
            b <= b + BW'(1);
          end
          c <= c_nx;
        end
        DATRD: dat_addr <= dat_addr + GBFOFM_ADDRWIDTH'(1);
        DATLD: begin
          dat_word <= GBFOFM_DatRd;
          b        <= '0;
          buf_v    <= 1'b1;
        end
        OUT:
          if (OFM_Rdy) begin
            vec_cnt <= vec_cnt + NUMVEC_WIDTH'(1);
            c       <= '0;
            if (!last_vec) begin
              dat <= '0;
              g   <= g + GW'(1);
            end
          end
        DONE: ;
      endcase
    end
  end

  assign GBFOFM_EnRd      = state == DATRD;
  assign GBFOFM_AddrRd    = dat_addr;
  assign GBFFLGOFM_EnRd   = state == FLGRD;
  assign GBFFLGOFM_AddrRd = flg_addr;
  assign OFM_Dat          = dat;
  assign OFM_Val          = state == OUT;
  assign UNPK_Busy        = state != IDLE;
  assign UNPK_Done        = state == DONE;

endmodule
